ddr3_wr_oe_sequencer: RTL and testbench

Write-path output-enable sequencer for the DDR3 controller. It turns each issued write command into the DQ/DQS tristate and strobe control needed by the LVDS/SSTL output buffers, whose enables are active-low (0 = drive, 1 = hi-Z). It covers write latency, DQS preamble and postamble, seamless back-to-back bursts and write-FIFO pop timing. It sits between the command scheduler and the I/O primitive layer, in the controller clock domain.

---
 rtl/ddr3_wr_oe_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ddr3_wr_oe_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_wr_oe_sequencer.sv
// rtl/ddr3_wr_oe_sequencer.sv - DDR3 write-path DQ/DQS output-enable sequencer
//
// Purpose: turns accepted write commands into active-low DQ/DQS buffer
// enables, DQS run/preamble control, write-FIFO pops and burst framing,
// CWL cycles after the command reaches the DRAM bus.
//
// Ports:
//   clk          controller clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr_cmd       one-cycle write command pulse
//   dqs_oe_n     DQS buffer enable (0 = drive, 1 = hi-Z)
//   dq_oe_n      DQ/DM buffer enable (0 = drive, 1 = hi-Z)
//   dqs_run      1 = DQS toggles, 0 = DQS held low
//   data_rd      write-data FIFO pop, one per data cycle
//   burst_last   final data cycle of a burst
//   busy         a write is in flight or an enable is asserted
//   err_overlap  one-cycle pulse after a rejected wr_cmd
module ddr3_wr_oe_sequencer #(
  parameter int CWL       = 5,
  parameter int BURST_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_cmd,
  output logic dqs_oe_n,
  output logic dq_oe_n,
  output logic dqs_run,
  output logic data_rd,
  output logic burst_last,
  output logic busy,
  output logic err_overlap
);

  localparam int CNT_W = (BURST_CYC > 1) ? $clog2(BURST_CYC) : 1;
  localparam int GAP_W = $clog2(BURST_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(BURST_CYC);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_POST} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CWL-2:0]   pipe_q, pipe_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             seen_q, seen_d;
  logic             ready_q, ready_d;
  logic             dqs_oe_n_q, dqs_oe_n_d;
  logic             dq_oe_n_q, dq_oe_n_d;
  logic             dqs_run_q, dqs_run_d;
  logic             data_rd_q, data_rd_d;
  logic             burst_last_q, burst_last_d;
  logic             busy_q, busy_d;
  logic             err_overlap_q, err_overlap_d;

  // age[k] = a command was accepted k cycles ago (age[0] is this cycle)
  logic [CWL-1:0]   age;
  logic             accept;
  logic             start_pre;
  logic             start_data;

  always_comb begin
    // ready_q masks the edge that coincides with reset release
    ready_d = 1'b1;
    accept  = wr_cmd & ready_q & (~seen_q | (gap_q >= GAP_MAX));
    err_overlap_d = wr_cmd & ready_q & ~accept;
    seen_d  = seen_q | accept;

    if (accept) begin
      gap_d = GAP_W'(1);
    end else if (gap_q < GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end

    age[0] = accept;
    for (int k = 1; k < CWL; k++) begin
      age[k] = pipe_q[k-1];
    end
    pipe_d     = age[CWL-2:0];
    // Decisions are made one cycle ahead because every output is registered
    start_pre  = age[CWL-2];
    start_data = age[CWL-1];

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_pre) state_d = S_PRE;
      end
      S_PRE: begin
        state_d = S_DATA;
        cnt_d   = CNT_LOAD;
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (start_data) begin
          // seamless follow-on burst
          cnt_d = CNT_LOAD;
        end else if (start_pre) begin
          // postamble of this burst doubles as the next preamble
          state_d = S_PRE;
        end else begin
          state_d = S_POST;
        end
      end
      S_POST: begin
        state_d = start_pre ? S_PRE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    dqs_oe_n_d   = (state_d == S_IDLE);
    dq_oe_n_d    = (state_d != S_DATA);
    dqs_run_d    = (state_d == S_DATA);
    data_rd_d    = (state_d == S_DATA);
    burst_last_d = (state_d == S_DATA) && (cnt_d == '0);
    busy_d       = (|pipe_d) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pipe_q        <= '0;
      gap_q         <= '0;
      seen_q        <= 1'b0;
      ready_q       <= 1'b0;
      dqs_oe_n_q    <= 1'b1;
      dq_oe_n_q     <= 1'b1;
      dqs_run_q     <= 1'b0;
      data_rd_q     <= 1'b0;
      burst_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_overlap_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pipe_q        <= pipe_d;
      gap_q         <= gap_d;
      seen_q        <= seen_d;
      ready_q       <= ready_d;
      dqs_oe_n_q    <= dqs_oe_n_d;
      dq_oe_n_q     <= dq_oe_n_d;
      dqs_run_q     <= dqs_run_d;
      data_rd_q     <= data_rd_d;
      burst_last_q  <= burst_last_d;
      busy_q        <= busy_d;
      err_overlap_q <= err_overlap_d;
    end
  end

  assign dqs_oe_n    = dqs_oe_n_q;
  assign dq_oe_n     = dq_oe_n_q;
  assign dqs_run     = dqs_run_q;
  assign data_rd     = data_rd_q;
  assign burst_last  = burst_last_q;
  assign busy        = busy_q;
  assign err_overlap = err_overlap_q;

endmodule

// File: tb/tb_ddr3_wr_oe_sequencer.sv
// tb/tb_ddr3_wr_oe_sequencer.sv - self-checking bench for ddr3_wr_oe_sequencer
module tb_ddr3_wr_oe_sequencer;

  localparam int MAXC = 128;
  localparam logic [6:0] RST_VAL = 7'b1100000;

  logic clk;
  logic rst_n;
  logic wr_a, wr_b;
  logic dqs_oe_n_a, dq_oe_n_a, dqs_run_a, data_rd_a, burst_last_a, busy_a, err_a;
  logic dqs_oe_n_b, dq_oe_n_b, dqs_run_b, data_rd_b, burst_last_b, busy_b, err_b;

  int passed = 0;
  int total  = 0;

  // per-cycle vector: {dqs_oe_n, dq_oe_n, dqs_run, data_rd, burst_last, busy, err_overlap}
  bit         cmd_a [MAXC];
  bit         cmd_b [MAXC];
  bit         mcmd  [MAXC];
  logic [6:0] obs_a [MAXC];
  logic [6:0] obs_b [MAXC];
  logic [6:0] exp_a [MAXC];
  logic [6:0] exp_b [MAXC];
  logic [6:0] mexp  [MAXC];

  ddr3_wr_oe_sequencer #(.CWL(5), .BURST_CYC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_cmd(wr_a),
    .dqs_oe_n(dqs_oe_n_a), .dq_oe_n(dq_oe_n_a), .dqs_run(dqs_run_a),
    .data_rd(data_rd_a), .burst_last(burst_last_a), .busy(busy_a),
    .err_overlap(err_a)
  );

  ddr3_wr_oe_sequencer #(.CWL(2), .BURST_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_cmd(wr_b),
    .dqs_oe_n(dqs_oe_n_b), .dq_oe_n(dq_oe_n_b), .dqs_run(dqs_run_b),
    .data_rd(data_rd_b), .burst_last(burst_last_b), .busy(busy_b),
    .err_overlap(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] vec_a();
    return {dqs_oe_n_a, dq_oe_n_a, dqs_run_a, data_rd_a, burst_last_a, busy_a, err_a};
  endfunction

  function automatic logic [6:0] vec_b();
    return {dqs_oe_n_b, dq_oe_n_b, dqs_run_b, data_rd_b, burst_last_b, busy_b, err_b};
  endfunction

  task automatic clear_cmds();
    for (int c = 0; c < MAXC; c++) begin
      cmd_a[c] = 1'b0;
      cmd_b[c] = 1'b0;
    end
  endtask

  // Cycle 0 is the cycle in which rst_n is released.
  task automatic run_case(input int n);
    rst_n = 1'b0;
    wr_a  = 1'b0;
    wr_b  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < n; c++) begin
      wr_a = cmd_a[c];
      wr_b = cmd_b[c];
      @(negedge clk);
      obs_a[c] = vec_a();
      obs_b[c] = vec_b();
      @(posedge clk);
      #1;
    end
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  // Reference: accepted commands become data windows, pre/postamble
  // cycles around each window, busy intervals and one-late reject pulses.
  task automatic model_run(input int n, input int cwl, input int bc);
    bit dat [MAXC];
    bit amb [MAXC];
    bit lst [MAXC];
    bit bsy [MAXC];
    bit err [MAXC];
    int last_acc;
    for (int c = 0; c < MAXC; c++) begin
      dat[c] = 0; amb[c] = 0; lst[c] = 0; bsy[c] = 0; err[c] = 0;
    end
    last_acc = -1;
    for (int c = 1; c < n; c++) begin
      if (mcmd[c]) begin
        if (last_acc < 0 || c - last_acc >= bc) begin
          last_acc = c;
          for (int i = 0; i < bc; i++)
            if (c + cwl + i < MAXC) dat[c + cwl + i] = 1;
          if (c + cwl + bc - 1 < MAXC) lst[c + cwl + bc - 1] = 1;
          if (c + cwl - 1 < MAXC) amb[c + cwl - 1] = 1;
          if (c + cwl + bc < MAXC) amb[c + cwl + bc] = 1;
          for (int k = c + 1; k <= c + cwl + bc; k++)
            if (k < MAXC) bsy[k] = 1;
        end else if (c + 1 < MAXC) begin
          err[c + 1] = 1;
        end
      end
    end
    for (int c = 0; c < MAXC; c++)
      mexp[c] = {!(dat[c] || amb[c]), !dat[c], dat[c], dat[c], lst[c], bsy[c], err[c]};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_a  = 1'b1;
    wr_b  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (vec_a() !== RST_VAL) $display("FAIL reset_a got %b want %b", vec_a(), RST_VAL);
    else passed++;
    total++;
    if (vec_b() !== RST_VAL) $display("FAIL reset_b got %b want %b", vec_b(), RST_VAL);
    else passed++;
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  task automatic test_release_ignore();
    clear_cmds();
    cmd_a[0] = 1'b1;
    cmd_b[0] = 1'b1;
    run_case(12);
    total++;
    if (obs_a[1][1] !== 1'b0 || obs_a[1][0] !== 1'b0)
      $display("FAIL release_ignore_a got %b want busy=0 err=0", obs_a[1]);
    else passed++;
    total++;
    if (obs_b[1][1] !== 1'b0 || obs_b[1][0] !== 1'b0)
      $display("FAIL release_ignore_b got %b want busy=0 err=0", obs_b[1]);
    else passed++;
  endtask

  task automatic test_single();
    clear_cmds();
    cmd_a[10] = 1'b1;
    run_case(30);
    mcmd = cmd_a;
    model_run(30, 5, 4);
    exp_a = mexp;
    for (int c = 0; c < 30; c++) begin
      total++;
      if (obs_a[c] !== exp_a[c]) $display("FAIL single cyc%0d got %b want %b", c, obs_a[c], exp_a[c]);
      else passed++;
    end
    total++;
    if (obs_a[14] !== 7'b0100010) $display("FAIL single_pre got %b want %b", obs_a[14], 7'b0100010);
    else passed++;
    total++;
    if (obs_a[18] !== 7'b0011110) $display("FAIL single_last got %b want %b", obs_a[18], 7'b0011110);
    else passed++;
    total++;
    if (obs_a[19] !== 7'b0100010) $display("FAIL single_post got %b want %b", obs_a[19], 7'b0100010);
    else passed++;
    total++;
    if (obs_a[20] !== 7'b1100000) $display("FAIL single_idle got %b want %b", obs_a[20], 7'b1100000);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int rd_cnt;
    clear_cmds();
    cmd_a[10] = 1'b1;
    cmd_a[14] = 1'b1;
    run_case(30);
    mcmd = cmd_a;
    model_run(30, 5, 4);
    exp_a = mexp;
    for (int c = 0; c < 30; c++) begin
      total++;
      if (obs_a[c] !== exp_a[c]) $display("FAIL b2b cyc%0d got %b want %b", c, obs_a[c], exp_a[c]);
      else passed++;
    end
    rd_cnt = 0;
    for (int c = 15; c <= 22; c++)
      if (obs_a[c][3] === 1'b1 && obs_a[c][5] === 1'b0) rd_cnt++;
    total++;
    if (rd_cnt != 8) $display("FAIL b2b_contiguous got %0d want %0d", rd_cnt, 8);
    else passed++;
    total++;
    if (obs_a[14] !== 7'b0100010 || obs_a[23] !== 7'b0100010)
      $display("FAIL b2b_pre_post got %b/%b want %b", obs_a[14], obs_a[23], 7'b0100010);
    else passed++;
    total++;
    if ({obs_a[18][2], obs_a[19][2], obs_a[22][2]} !== 3'b101)
      $display("FAIL b2b_last got %b want %b", {obs_a[18][2], obs_a[19][2], obs_a[22][2]}, 3'b101);
    else passed++;
  endtask

  task automatic test_gap5();
    int dq_hiz;
    int dqs_hiz;
    clear_cmds();
    cmd_a[10] = 1'b1;
    cmd_a[15] = 1'b1;
    run_case(30);
    mcmd = cmd_a;
    model_run(30, 5, 4);
    exp_a = mexp;
    for (int c = 0; c < 30; c++) begin
      total++;
      if (obs_a[c] !== exp_a[c]) $display("FAIL gap5 cyc%0d got %b want %b", c, obs_a[c], exp_a[c]);
      else passed++;
    end
    dq_hiz  = 0;
    dqs_hiz = 0;
    for (int c = 15; c <= 23; c++) if (obs_a[c][5] !== 1'b0) dq_hiz++;
    for (int c = 14; c <= 24; c++) if (obs_a[c][6] !== 1'b0) dqs_hiz++;
    total++;
    if (dq_hiz != 1 || obs_a[19][5] !== 1'b1)
      $display("FAIL gap5_dq got %0d hi-Z cycles (cyc19=%b) want 1 at 19", dq_hiz, obs_a[19][5]);
    else passed++;
    total++;
    if (dqs_hiz != 0 || obs_a[19][4] !== 1'b0)
      $display("FAIL gap5_dqs got %0d hi-Z cycles, run@19=%b want 0, 0", dqs_hiz, obs_a[19][4]);
    else passed++;
  endtask

  task automatic test_overlap();
    clear_cmds();
    cmd_a[10] = 1'b1;
    cmd_a[12] = 1'b1;
    run_case(30);
    mcmd = cmd_a;
    model_run(30, 5, 4);
    exp_a = mexp;
    for (int c = 0; c < 30; c++) begin
      total++;
      if (obs_a[c] !== exp_a[c]) $display("FAIL overlap cyc%0d got %b want %b", c, obs_a[c], exp_a[c]);
      else passed++;
    end
    total++;
    if (obs_a[13] !== 7'b1100011 || obs_a[14][0] !== 1'b0)
      $display("FAIL overlap_err got %b/%b want %b/0", obs_a[13], obs_a[14][0], 7'b1100011);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    clear_cmds();
    cmd_a[10] = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      wr_a = cmd_a[c];
      @(posedge clk);
      #1;
    end
    wr_a = 1'b0;
    total++;
    if (data_rd_a !== 1'b1) $display("FAIL midrst_pre got data_rd=%b want 1", data_rd_a);
    else passed++;
    rst_n = 1'b0;
    #2;
    total++;
    if (vec_a() !== RST_VAL) $display("FAIL midrst_async got %b want %b", vec_a(), RST_VAL);
    else passed++;
    clear_cmds();
    cmd_a[4] = 1'b1;
    run_case(20);
    mcmd = cmd_a;
    model_run(20, 5, 4);
    exp_a = mexp;
    for (int c = 0; c < 20; c++) begin
      total++;
      if (obs_a[c] !== exp_a[c]) $display("FAIL midrst_after cyc%0d got %b want %b", c, obs_a[c], exp_a[c]);
      else passed++;
    end
  endtask

  task automatic test_sweep();
    int rd_cnt;
    int err_cnt;
    clear_cmds();
    for (int c = 1; c <= 40; c++) cmd_b[c] = 1'b1;
    run_case(46);
    mcmd = cmd_b;
    model_run(46, 2, 1);
    exp_b = mexp;
    for (int c = 0; c < 46; c++) begin
      total++;
      if (obs_b[c] !== exp_b[c]) $display("FAIL sweep cyc%0d got %b want %b", c, obs_b[c], exp_b[c]);
      else passed++;
    end
    rd_cnt  = 0;
    err_cnt = 0;
    for (int c = 3; c <= 42; c++) if (obs_b[c][3] === 1'b1 && obs_b[c][2] === 1'b1) rd_cnt++;
    for (int c = 0; c < 46; c++) if (obs_b[c][0] !== 1'b0) err_cnt++;
    total++;
    if (rd_cnt != 40) $display("FAIL sweep_rd got %0d want %0d", rd_cnt, 40);
    else passed++;
    total++;
    if (err_cnt != 0) $display("FAIL sweep_err got %0d want %0d", err_cnt, 0);
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int pa;
      int pb;
      clear_cmds();
      pa = int'($urandom_range(0, 6));
      pb = int'($urandom_range(0, 3));
      for (int c = 0; c < 80; c++) begin
        cmd_a[c] = ($urandom_range(0, pa) == 0);
        cmd_b[c] = ($urandom_range(0, pb) == 0);
      end
      run_case(90);
      mcmd = cmd_a;
      model_run(90, 5, 4);
      exp_a = mexp;
      mcmd = cmd_b;
      model_run(90, 2, 1);
      exp_b = mexp;
      for (int c = 0; c < 90; c++) begin
        total++;
        if (obs_a[c] !== exp_a[c]) $display("FAIL rand_a it%0d cyc%0d got %b want %b", it, c, obs_a[c], exp_a[c]);
        else passed++;
        total++;
        if (obs_b[c] !== exp_b[c]) $display("FAIL rand_b it%0d cyc%0d got %b want %b", it, c, obs_b[c], exp_b[c]);
        else passed++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_a  = 1'b0;
    wr_b  = 1'b0;
    test_reset();
    test_release_ignore();
    test_single();
    test_back_to_back();
    test_gap5();
    test_overlap();
    test_reset_mid_burst();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
